// File: rtl/srs_re_extract.sv
// SRS resource-element extractor: walks a comb of FFT bins in the FFT output RAM
// and streams the selected REs through a small skid buffer with ready/valid.
module srs_re_extract #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [1:0]  ifft_size_sel,
  input  logic        ktc,
  input  logic [10:0] m_sc,
  input  logic [11:0] re_start,
  output logic        fft_ram_rd,
  output logic [11:0] fft_ram_raddr,
  input  logic [23:0] fft_ram_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
  output logic [10:0] out_index,
  output logic        out_last
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [12:0] n_reg;
  logic [2:0]  step_reg;
  logic [10:0] m_sc_reg;
  logic [11:0] addr_reg, addr_next;
  logic [10:0] rd_cnt_reg;
  logic        flight_reg, flight_last_reg;
  logic [10:0] flight_idx_reg;
  logic        done_reg, tail_reg;

  logic [23:0]   buf_data [BUF_DEPTH];
  logic [10:0]   buf_idx  [BUF_DEPTH];
  logic          buf_last [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] cnt_reg;

  logic          accept, pop, push, issue, last_read, run_end;
  logic [CW:0]   occ_after_pop;
  logic [12:0]   n_in, sum;
  logic [11:0]   mask_in;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // busy stays up through the done cycle so a start there is ignored
  assign busy      = (state_reg != IDLE) | tail_reg;
  assign done      = done_reg;
  assign accept    = start & ~busy;
  assign n_in      = 13'd4096 >> ifft_size_sel;
  assign mask_in   = 12'hFFF >> ifft_size_sel;

  assign sum       = {1'b0, addr_reg} + {10'd0, step_reg};
  assign addr_next = (sum >= n_reg) ? (sum[11:0] - n_reg[11:0]) : sum[11:0];

  assign out_valid = (cnt_reg != '0);
  assign out_data  = buf_data[rd_ptr_reg];
  assign out_index = buf_idx[rd_ptr_reg];
  assign out_last  = buf_last[rd_ptr_reg];
  assign pop       = out_valid & out_ready;
  assign push      = flight_reg;

  // A slot freed by this cycle's pop counts as credit, giving 1 RE/cycle with 2 entries
  assign occ_after_pop = {1'b0, cnt_reg} + (CW+1)'(flight_reg) - (CW+1)'(pop);
  assign issue         = (state_reg == RUN) && (occ_after_pop < (CW+1)'(BUF_DEPTH));
  assign last_read     = (rd_cnt_reg == m_sc_reg - 11'd1);
  assign run_end       = (state_reg == DRAIN) & pop & out_last;

  assign fft_ram_rd    = issue;
  assign fft_ram_raddr = addr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && m_sc != 11'd0) state_next = RUN;
      RUN:     if (issue && last_read)      state_next = DRAIN;
      DRAIN:   if (run_end)                 state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      n_reg           <= '0;
      step_reg        <= '0;
      m_sc_reg        <= '0;
      addr_reg        <= '0;
      rd_cnt_reg      <= '0;
      flight_reg      <= 1'b0;
      flight_idx_reg  <= '0;
      flight_last_reg <= 1'b0;
      done_reg        <= 1'b0;
      tail_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      done_reg        <= run_end | (accept & (m_sc == 11'd0));
      tail_reg        <= run_end;
      if (accept) begin
        n_reg      <= n_in;
        step_reg   <= ktc ? 3'd4 : 3'd2;
        m_sc_reg   <= m_sc;
        addr_reg   <= re_start & mask_in;
        rd_cnt_reg <= '0;
      end else if (issue) begin
        addr_reg   <= addr_next;
        rd_cnt_reg <= rd_cnt_reg + 11'd1;
      end
      flight_reg      <= issue;
      flight_idx_reg  <= rd_cnt_reg;
      flight_last_reg <= last_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_idx[i]  <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr_reg] <= fft_ram_rdata;
        buf_idx[wr_ptr_reg]  <= flight_idx_reg;
        buf_last[wr_ptr_reg] <= flight_last_reg;
        wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      cnt_reg <= cnt_reg + 1'b1;
      else if (pop && !push) cnt_reg <= cnt_reg - 1'b1;
    end
  end
endmodule

// File: tb/tb_srs_re_extract.sv
// Directed bench for srs_re_extract: RAM model, negedge monitor, per-run checks.
module tb_srs_re_extract;
  logic        clk, rst_n, start, busy, done, ktc, fft_ram_rd, out_valid, out_ready, out_last;
  logic [1:0]  ifft_size_sel;
  logic [10:0] m_sc, out_index;
  logic [11:0] re_start, fft_ram_raddr;
  logic [23:0] fft_ram_rdata, out_data;

  srs_re_extract #(.BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ifft_size_sel(ifft_size_sel), .ktc(ktc), .m_sc(m_sc), .re_start(re_start),
    .fft_ram_rd(fft_ram_rd), .fft_ram_raddr(fft_ram_raddr), .fft_ram_rdata(fft_ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  bit rand_ready = 0;
  int rd_q[$], rd_c_q[$], beat_i_q[$], beat_c_q[$], done_q[$];
  logic [23:0] beat_d_q[$];
  bit beat_l_q[$], done_busy_q[$];
  int reads_total = 0, pops_total = 0, dropped = 0, max_out = 0, stab_err = 0, busy_cycles = 0;
  bit prev_stall = 0, prev_l = 0;
  logic [23:0] prev_d = '0;
  logic [10:0] prev_i = '0;
  int rb, bb, db, busyb, st_cyc, drive_cyc;

  function automatic logic [23:0] ram_word(input logic [11:0] a);
    logic [11:0] i_part, q_part;
    i_part = a * 12'd7 + 12'd5;
    q_part = ~a;
    return {i_part, q_part};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
    fft_ram_rdata <= fft_ram_rd ? ram_word(fft_ram_raddr) : 24'h5A5A5A;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      dropped = reads_total - pops_total;
      prev_stall = 0;
    end else begin
      if (fft_ram_rd) begin
        rd_q.push_back(int'(fft_ram_raddr));
        rd_c_q.push_back(cyc);
        reads_total++;
      end
      if (prev_stall && (!out_valid || out_data !== prev_d || out_index !== prev_i || out_last !== prev_l))
        stab_err++;
      if (out_valid && out_ready) begin
        beat_d_q.push_back(out_data);
        beat_i_q.push_back(int'(out_index));
        beat_l_q.push_back(out_last);
        beat_c_q.push_back(cyc);
        pops_total++;
      end
      if (done) begin
        done_q.push_back(cyc);
        done_busy_q.push_back(busy);
      end
      if (busy) busy_cycles++;
      if (reads_total - pops_total - dropped > max_out) max_out = reads_total - pops_total - dropped;
      prev_stall = out_valid & ~out_ready;
      prev_d = out_data;
      prev_i = out_index;
      prev_l = out_last;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic snap();
    rb = rd_q.size(); bb = beat_d_q.size(); db = done_q.size(); busyb = busy_cycles;
  endtask

  task automatic drive_start(input int sel, input int kt, input int m, input int rs);
    @(posedge clk); #1;
    ifft_size_sel = 2'(sel); ktc = 1'(kt); m_sc = 11'(m); re_start = 12'(rs);
    start = 1'b1;
    drive_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    ifft_size_sel = ~ifft_size_sel; ktc = ~ktc; m_sc = 11'd7; re_start = 12'hABC;
  endtask

  task automatic pulse_start(input int sel, input int kt, input int m, input int rs);
    drive_start(sel, kt, m, rs);
    st_cyc = drive_cyc;
  endtask

  task automatic finish_check(input string tag, input int sel, input int kt, input int m,
                              input int rs, input bit unloaded, input int bound);
    int n, s, a0, nr, nb, ae, de, got, exp_a;
    got = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_q.size() > db) begin got = 1; break; end
      @(posedge clk);
    end
    check({tag, ".done_seen"}, got, 1);
    repeat (2) @(posedge clk);
    #1;
    n = 4096 >> sel; s = kt ? 4 : 2; a0 = rs & (n - 1);
    nr = rd_q.size() - rb; nb = beat_d_q.size() - bb;
    check({tag, ".n_reads"}, nr, m);
    check({tag, ".n_beats"}, nb, m);
    ae = 0; de = 0;
    for (int k = 0; k < nr && k < m; k++) begin
      exp_a = (a0 + k * s) % n;
      if (rd_q[rb + k] != exp_a) ae++;
    end
    for (int k = 0; k < nb && k < m; k++) begin
      exp_a = (a0 + k * s) % n;
      if (beat_d_q[bb + k] !== ram_word(12'(exp_a)) || beat_i_q[bb + k] != k ||
          beat_l_q[bb + k] != (k == m - 1)) de++;
    end
    check({tag, ".addr_err"}, ae, 0);
    check({tag, ".beat_err"}, de, 0);
    check({tag, ".n_done"}, done_q.size() - db, 1);
    if (got == 1 && m > 0 && nb > 0) begin
      check({tag, ".done_after_last"}, done_q[db] - beat_c_q[bb + nb - 1], 1);
      check({tag, ".busy_at_done"}, done_busy_q[db], 1);
    end
    if (got == 1 && m == 0) begin
      check({tag, ".done_latency"}, done_q[db] - st_cyc, 1);
      check({tag, ".busy_cycles"}, busy_cycles - busyb, 0);
    end
    if (unloaded && m > 0 && nr > 0 && nb > 0) begin
      check({tag, ".first_read_lat"}, rd_c_q[rb] - st_cyc, 1);
      check({tag, ".read_span"}, rd_c_q[rb + nr - 1] - rd_c_q[rb], m - 1);
      check({tag, ".first_valid_lat"}, beat_c_q[bb] - st_cyc, 3);
    end
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".done_after"}, done, 0);
    $display("run %s: sel=%0d ktc=%0d m_sc=%0d re_start=%0d reads=%0d beats=%0d",
             tag, sel, kt, m, rs, nr, nb);
  endtask

  task automatic run_check(input string tag, input int sel, input int kt, input int m,
                           input int rs, input bit unloaded, input int bound);
    snap();
    pulse_start(sel, kt, m, rs);
    finish_check(tag, sel, kt, m, rs, unloaded, bound);
  endtask

  int exp033[4] = '{10, 12, 14, 16};
  int exp034[4] = '{506, 510, 2, 6};
  int rd_before, done_before, got5;

  initial begin
    rst_n = 0; start = 0; ifft_size_sel = 0; ktc = 0; m_sc = 0; re_start = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.rd", fft_ram_rd, 0);
    check("rst.raddr", fft_ram_raddr, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_data", out_data, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);

    run_check("basic512", 3, 0, 4, 10, 1, 200);
    for (int k = 0; k < 4; k++) check("basic512.addr", rd_q[rb + k], exp033[k]);
    run_check("wrap512", 3, 1, 4, 506, 1, 200);
    for (int k = 0; k < 4; k++) check("wrap512.addr", rd_q[rb + k], exp034[k]);
    run_check("empty", 0, 0, 0, 55, 1, 50);
    run_check("mask1024", 2, 1, 5, 12'hFFE, 1, 200);

    rand_ready = 1;
    run_check("full4096", 0, 0, 1536, 0, 0, 8000);
    rand_ready = 0;

    // start while busy must not disturb the run in progress
    snap();
    pulse_start(2, 0, 6, 100);
    drive_start(3, 1, 3, 7);
    finish_check("busy_ignore", 2, 0, 6, 100, 1, 200);

    // start raised in the done cycle is ignored
    snap();
    pulse_start(3, 0, 2, 20);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) break;
    end
    ifft_size_sel = 2'd1; ktc = 1'b1; m_sc = 11'd3; re_start = 12'd40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_check("done_cycle_start", 3, 0, 2, 20, 1, 50);
    run_check("after_done", 1, 1, 3, 40, 1, 200);

    // asynchronous reset in the middle of a run
    snap();
    pulse_start(1, 0, 20, 3);
    got5 = 0;
    for (int i = 0; i < 100; i++) begin
      if (rd_q.size() - rb >= 5) begin got5 = 1; break; end
      @(posedge clk);
    end
    check("midrst.reached_k5", got5, 1);
    #1 rst_n = 0;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.rd", fft_ram_rd, 0);
    check("midrst.raddr", fft_ram_raddr, 0);
    check("midrst.out_valid", out_valid, 0);
    check("midrst.out_data", out_data, 0);
    check("midrst.out_index", out_index, 0);
    check("midrst.out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    rd_before = rd_q.size(); done_before = done_q.size();
    repeat (5) @(posedge clk);
    #1;
    check("midrst.idle_reads", rd_q.size() - rd_before, 0);
    check("midrst.idle_done", done_q.size() - done_before, 0);
    check("midrst.idle_valid", out_valid, 0);
    check("midrst.idle_busy", busy, 0);
    run_check("post_reset", 1, 0, 20, 3, 1, 200);

    check("max_outstanding_le2", (max_out <= 2), 1);
    check("stable_under_stall", stab_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/srs_re_extract.md
SRS_RE_EXTRACT -- requirements
Module: srs_re_extract

Interface
REQ-001 Parameter BUF_DEPTH, default 2, output skid-buffer depth in entries (fixed at 2 for this revision).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle pulse; samples config, begins extraction; ignored while busy=1.
REQ-005 busy  output  1  high from cycle after accepted start until the cycle done is asserted.
REQ-006 done  output  1  one-cycle pulse at end of extraction.
REQ-007 ifft_size_sel  input  2  FFT size: 0=4096, 1=2048, 2=1024, 3=512.
REQ-008 ktc  input  1  comb: 0 = step 2 bins, 1 = step 4 bins.
REQ-009 m_sc  input  11  number of SRS REs to extract (0..1536).
REQ-010 re_start  input  12  FFT bin of first SRS RE.
REQ-011 fft_ram_rd  output  1  FFT output RAM read strobe.
REQ-012 fft_ram_raddr  output  12  read address (bin).
REQ-013 fft_ram_rdata  input  24  {I[11:0], Q[11:0]}, valid exactly 1 cycle after fft_ram_rd.
REQ-014 out_valid  output  1  extracted RE available.
REQ-015 out_ready  input  1  downstream accepts when out_valid&out_ready.
REQ-016 out_data  output  24  {I, Q} of current RE, unmodified from RAM.
REQ-017 out_index  output  11  RE ordinal k, 0..m_sc-1.
REQ-018 out_last  output  1  high with out_valid when k = m_sc-1.

Function
REQ-019 Config (ifft_size_sel, ktc, m_sc, re_start) SHALL be registered on accepted start and held constant for the run.
REQ-020 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start with m_sc!=0; IDLE->done pulse next cycle, no reads, when m_sc=0.
REQ-021 RUN->DRAIN when read count reaches m_sc; DRAIN->IDLE when last beat accepted, done pulses that same transition's following cycle.
REQ-022 Read address k SHALL be (re_start_masked + k*S) mod N, S=2 or 4, N=ifft size; re_start_masked = re_start & (N-1).
REQ-023 Wrap: next_addr = addr+S-N when addr+S >= N, else addr+S; 12-bit arithmetic, no overflow.
REQ-024 First fft_ram_rd SHALL occur the cycle after start; back-to-back reads, one per cycle, when no backpressure.
REQ-025 A read SHALL be issued only when (buffered entries + reads in flight) < BUF_DEPTH; no RAM data is ever dropped.
REQ-026 Returned rdata SHALL enter the buffer in order with its k; out_data/out_index/out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Unloaded throughput: 1 RE/cycle; latency start->first out_valid = 3 cycles.
REQ-028 Exactly m_sc reads and m_sc output beats per run; fft_ram_rd never asserted in IDLE.
REQ-029 Simultaneous buffer push and pop SHALL keep occupancy unchanged.
REQ-030 done and busy fall in the same cycle; start in that cycle is ignored, accepted the next.

Reset
REQ-031 On rst_n low (any time, including mid-run): busy=0, done=0, fft_ram_rd=0, fft_ram_raddr=0, out_valid=0, out_data=0, out_index=0, out_last=0, FSM=IDLE, buffer empty, in-flight read discarded.
REQ-032 After reset release, first action SHALL await a new start.

Verification
REQ-033 sel=3 (512), ktc=0, re_start=10, m_sc=4, out_ready=1 -> reads 10,12,14,16 on consecutive cycles; 4 beats, out_last on k=3; done once.
REQ-034 sel=3, ktc=1, re_start=506, m_sc=4 -> addresses 506,510,2,6 (wrap); data matches RAM model.
REQ-035 sel=0, ktc=0, re_start=0, m_sc=1536, out_ready random 50% -> 1536 beats in order, no loss/duplication, never >2 outstanding.
REQ-036 m_sc=0 start -> no fft_ram_rd, done pulse 1 cycle later, busy never 1.
REQ-037 rst_n low at k=5 of m_sc=20 run -> all outputs 0 next edge; new start runs cleanly from k=0.
REQ-038 start pulsed while busy -> ignored, config unchanged, beat count equals original m_sc.
